// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2_ADV DRP reconfiguration sequencer.
// The readback-verify states exist only when PLL_DRP_READBACK_EN is defined.
package pll_drp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_ASSERT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
`ifdef PLL_DRP_READBACK_EN
    ST_VF_REQ,
    ST_VF_WAIT,
`endif
    ST_NEXT,
    ST_RST_HOLD,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic {
    ACC_IDLE,
    ACC_WAIT
  } acc_state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_DRDY   = 2'd1;
  localparam logic [1:0] ERR_LOCK   = 2'd2;
  localparam logic [1:0] ERR_VERIFY = 2'd3;

  // PLLE2_ADV DRP register map
  localparam logic [6:0] DRP_CLKOUT5_REG1  = 7'h06;
  localparam logic [6:0] DRP_CLKOUT5_REG2  = 7'h07;
  localparam logic [6:0] DRP_CLKOUT0_REG1  = 7'h08;
  localparam logic [6:0] DRP_CLKOUT0_REG2  = 7'h09;
  localparam logic [6:0] DRP_CLKOUT1_REG1  = 7'h0A;
  localparam logic [6:0] DRP_CLKOUT1_REG2  = 7'h0B;
  localparam logic [6:0] DRP_CLKOUT2_REG1  = 7'h0C;
  localparam logic [6:0] DRP_CLKOUT2_REG2  = 7'h0D;
  localparam logic [6:0] DRP_CLKOUT3_REG1  = 7'h0E;
  localparam logic [6:0] DRP_CLKOUT3_REG2  = 7'h0F;
  localparam logic [6:0] DRP_CLKOUT4_REG1  = 7'h10;
  localparam logic [6:0] DRP_CLKOUT4_REG2  = 7'h11;
  localparam logic [6:0] DRP_CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] DRP_CLKFBOUT_REG2 = 7'h15;

  // Mask bit 1 keeps the value read back from the PLL
  function automatic logic [15:0] rmw_merge(input logic [15:0] rd,
                                            input logic [15:0] mask,
                                            input logic [15:0] data);
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/pll_drp_access.sv
// Single DRP read or write: one-cycle DEN, then wait for DRDY or time out.
// Returns a one-cycle ack (with rdata) or a one-cycle timeout pulse.
import pll_drp_pkg::*;

module pll_drp_access #(
  parameter int unsigned DRDY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        timeout,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  localparam int unsigned CNT_W = $clog2(DRDY_TIMEOUT + 1);

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             den_q, den_d;
  logic             dwe_q, dwe_d;
  logic [6:0]       daddr_q, daddr_d;
  logic [15:0]      di_q, di_d;
  logic             ack_q, ack_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      rdata_q, rdata_d;

  // DRDY is only honoured while a transaction is outstanding
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    den_d     = 1'b0;
    dwe_d     = 1'b0;
    daddr_d   = daddr_q;
    di_d      = di_q;
    ack_d     = 1'b0;
    timeout_d = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      ACC_IDLE: begin
        if (req) begin
          den_d   = 1'b1;
          dwe_d   = we;
          daddr_d = addr;
          if (we) di_d = wdata;
          cnt_d   = '0;
          state_d = ACC_WAIT;
        end
      end
      ACC_WAIT: begin
        if (drp_drdy) begin
          ack_d   = 1'b1;
          rdata_d = drp_do;
          state_d = ACC_IDLE;
        end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ACC_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACC_IDLE;
      cnt_q     <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign timeout   = timeout_q;
  assign drp_den   = den_q;
  assign drp_dwe   = dwe_q;
  assign drp_daddr = daddr_q;
  assign drp_di    = di_q;

endmodule

// File: rtl/pll_drp_reconfig_ctrl.sv
// Reprograms a PLLE2_ADV through DRP: hold reset, masked RMW of each entry, release, await lock.
// Define PLL_DRP_READBACK_EN to re-read every written register and flag mismatches.
import pll_drp_pkg::*;

module pll_drp_reconfig_ctrl #(
  parameter int unsigned ENTRIES      = 8,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned RST_HOLD     = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           start,
  input  logic [$clog2(ENTRIES+1)-1:0]   num,
  input  logic [ENTRIES*7-1:0]           cfg_addr,
  input  logic [ENTRIES*16-1:0]          cfg_mask,
  input  logic [ENTRIES*16-1:0]          cfg_data,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [1:0]                     err_code,
  output logic [6:0]                     drp_daddr,
  output logic                           drp_den,
  output logic                           drp_dwe,
  output logic [15:0]                    drp_di,
  input  logic [15:0]                    drp_do,
  input  logic                           drp_drdy,
  output logic                           pll_rst,
  input  logic                           pll_locked
);

  localparam int unsigned NUM_W   = $clog2(ENTRIES + 1);
  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [6:0]       addr_q [ENTRIES];
  logic [6:0]       addr_d [ENTRIES];
  logic [15:0]      mask_q [ENTRIES];
  logic [15:0]      mask_d [ENTRIES];
  logic [15:0]      data_q [ENTRIES];
  logic [15:0]      data_d [ENTRIES];
  logic [15:0]      rd_q, rd_d;
`ifdef PLL_DRP_READBACK_EN
  logic [15:0]      wr_q, wr_d;
`endif
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             pll_rst_q, pll_rst_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_sync_q, lock_sync_d;

  logic [IDX_W-1:0] sel_c;
  logic [6:0]       cur_addr_c;
  logic [15:0]      wr_val_c;
  logic             acc_req_c;
  logic             acc_we_c;
  logic             acc_ack;
  logic             acc_timeout;
  logic [15:0]      acc_rdata;

  assign sel_c      = idx_q[IDX_W-1:0];
  assign cur_addr_c = addr_q[sel_c];
  assign wr_val_c   = rmw_merge(rd_q, mask_q[sel_c], data_q[sel_c]);

  pll_drp_access #(
    .DRDY_TIMEOUT (DRDY_TIMEOUT)
  ) u_access (
    .clk       (aclk),
    .rst_n     (aresetn),
    .req       (acc_req_c),
    .we        (acc_we_c),
    .addr      (cur_addr_c),
    .wdata     (wr_val_c),
    .ack       (acc_ack),
    .rdata     (acc_rdata),
    .timeout   (acc_timeout),
    .drp_daddr (drp_daddr),
    .drp_den   (drp_den),
    .drp_dwe   (drp_dwe),
    .drp_di    (drp_di),
    .drp_do    (drp_do),
    .drp_drdy  (drp_drdy)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    data_d      = data_q;
    rd_d        = rd_q;
`ifdef PLL_DRP_READBACK_EN
    wr_d        = wr_q;
`endif
    cnt_d       = cnt_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    lock_meta_d = pll_locked;
    lock_sync_d = lock_meta_q;
    acc_req_c   = 1'b0;
    acc_we_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d = (num > NUM_W'(ENTRIES)) ? NUM_W'(ENTRIES) : num;
          for (int i = 0; i < int'(ENTRIES); i++) begin
            addr_d[i] = cfg_addr[i*7 +: 7];
            mask_d[i] = cfg_mask[i*16 +: 16];
            data_d[i] = cfg_data[i*16 +: 16];
          end
          idx_d      = '0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = ST_RST_ASSERT;
        end
      end
      ST_RST_ASSERT: begin
        cnt_d   = '0;
        state_d = (num_q == '0) ? ST_RST_HOLD : ST_RD_REQ;
      end
      ST_RD_REQ: begin
        acc_req_c = 1'b1;
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (acc_ack) begin
          rd_d    = acc_rdata;
          state_d = ST_WR_REQ;
        end else if (acc_timeout) begin
          error_d    = 1'b1;
          err_code_d = ERR_DRDY;
          state_d    = ST_ERROR;
        end
      end
      ST_WR_REQ: begin
        acc_req_c = 1'b1;
        acc_we_c  = 1'b1;
`ifdef PLL_DRP_READBACK_EN
        wr_d      = wr_val_c;
`endif
        state_d   = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (acc_ack) begin
`ifdef PLL_DRP_READBACK_EN
          state_d = ST_VF_REQ;
`else
          state_d = ST_NEXT;
`endif
        end else if (acc_timeout) begin
          error_d    = 1'b1;
          err_code_d = ERR_DRDY;
          state_d    = ST_ERROR;
        end
      end
`ifdef PLL_DRP_READBACK_EN
      ST_VF_REQ: begin
        acc_req_c = 1'b1;
        state_d   = ST_VF_WAIT;
      end
      ST_VF_WAIT: begin
        if (acc_ack) begin
          if (acc_rdata != wr_q) begin
            error_d    = 1'b1;
            err_code_d = ERR_VERIFY;
            state_d    = ST_ERROR;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (acc_timeout) begin
          error_d    = 1'b1;
          err_code_d = ERR_DRDY;
          state_d    = ST_ERROR;
        end
      end
`endif
      ST_NEXT: begin
        idx_d   = idx_q + NUM_W'(1);
        cnt_d   = '0;
        state_d = ((idx_q + NUM_W'(1)) == num_q) ? ST_RST_HOLD : ST_RD_REQ;
      end
      ST_RST_HOLD: begin
        if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync_q) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          error_d    = 1'b1;
          err_code_d = ERR_LOCK;
          state_d    = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Status outputs track the state being entered so they are registered, not decoded
    busy_d    = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
    done_d    = (state_d == ST_DONE);
    pll_rst_d = !(state_d inside {ST_IDLE, ST_WAIT_LOCK, ST_DONE, ST_ERROR});
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      num_q       <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        addr_q[i] <= '0;
        mask_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_q        <= '0;
`ifdef PLL_DRP_READBACK_EN
      wr_q        <= '0;
`endif
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      pll_rst_q   <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
`ifdef PLL_DRP_READBACK_EN
      wr_q        <= wr_d;
`endif
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      pll_rst_q   <= pll_rst_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;
  assign pll_rst  = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// Directed bench for pll_drp_reconfig_ctrl with a behavioural PLL DRP/LOCKED model.
// Expectations follow PLL_DRP_READBACK_EN when it is defined for the build.
module tb_pll_drp_reconfig_ctrl;
  import pll_drp_pkg::*;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned NUM_W   = 4;
`ifdef PLL_DRP_READBACK_EN
  localparam int TXN_PER_ENTRY = 3;
`else
  localparam int TXN_PER_ENTRY = 2;
`endif

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic                   start;
  logic [NUM_W-1:0]       num;
  logic [ENTRIES*7-1:0]   cfg_addr;
  logic [ENTRIES*16-1:0]  cfg_mask;
  logic [ENTRIES*16-1:0]  cfg_data;
  logic                   busy, done, error;
  logic [1:0]             err_code;
  logic [6:0]             drp_daddr;
  logic                   drp_den, drp_dwe;
  logic [15:0]            drp_di;
  logic [15:0]            drp_do;
  logic                   drp_drdy;
  logic                   pll_rst;
  logic                   pll_locked;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  pll_drp_reconfig_ctrl dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .num        (num),
    .cfg_addr   (cfg_addr),
    .cfg_mask   (cfg_mask),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .drp_daddr  (drp_daddr),
    .drp_den    (drp_den),
    .drp_dwe    (drp_dwe),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_drdy   (drp_drdy),
    .pll_rst    (pll_rst),
    .pll_locked (pll_locked)
  );

  // PLL model: DRDY three cycles after DEN, LOCKED follows released reset
  logic [15:0] mem [128];
  logic        m_fill, m_rdy_en, m_corrupt, lock_en;
  logic        m_pend, m_we;
  logic [1:0]  m_cnt;
  logic [6:0]  m_addr;
  logic [15:0] m_di;

  always @(posedge aclk) begin
    drp_drdy   <= 1'b0;
    pll_locked <= lock_en && !pll_rst;
    if (m_fill) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'hFFFF;
      m_pend <= 1'b0;
      m_cnt  <= 2'd0;
      drp_do <= 16'h0000;
    end else begin
      if (m_pend) begin
        if (m_cnt == 2'd1) begin
          m_pend <= 1'b0;
          if (m_rdy_en) begin
            drp_drdy <= 1'b1;
            drp_do   <= mem[m_addr] ^ (m_corrupt ? 16'h0001 : 16'h0000);
            if (m_we) mem[m_addr] <= m_di;
          end
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end
      if (drp_den) begin
        m_pend <= 1'b1;
        m_cnt  <= 2'd0;
        m_we   <= drp_dwe;
        m_addr <= drp_daddr;
        m_di   <= drp_di;
      end
    end
  end

  // Free-running event counters; the stimulus takes deltas around each run
  int den_cnt = 0, wr_cnt = 0, den_norst = 0, den_ovl = 0, rst_cnt = 0, done_cnt = 0;
  logic [15:0] last_di = '0;
  logic [6:0]  last_wa = '0;

  always @(negedge aclk) begin
    if (drp_den) begin
      den_cnt++;
      if (!pll_rst) den_norst++;
      if (m_pend) den_ovl++;
      if (drp_dwe) begin
        wr_cnt++;
        last_di = drp_di;
        last_wa = drp_daddr;
      end
    end
    if (pll_rst) rst_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [6:0] a, input logic [15:0] m,
                           input logic [15:0] d);
    cfg_addr[i*7 +: 7]   = a;
    cfg_mask[i*16 +: 16] = m;
    cfg_data[i*16 +: 16] = d;
  endtask

  task automatic pulse_start(input int n);
    @(negedge aclk);
    num   = NUM_W'(n);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic refill();
    @(negedge aclk);
    m_fill = 1'b1;
    @(negedge aclk);
    m_fill = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!(done || error) && cycles < budget) begin
      @(negedge aclk);
      cycles++;
    end
    check({tag, "_expired"}, 32'(cycles >= budget), 32'd0);
  endtask

  int cyc, d0, w0, r0, n0, o0, k0;

  initial begin
    aresetn = 1'b0; start = 1'b0; num = '0;
    cfg_addr = '0; cfg_mask = '0; cfg_data = '0;
    m_fill = 1'b1; m_rdy_en = 1'b1; m_corrupt = 1'b0; lock_en = 1'b1;
    repeat (4) @(negedge aclk);
    m_fill = 1'b0;
    check("rst_ctrl", {busy, done, error, err_code, drp_den, drp_dwe, pll_rst}, 32'd0);
    check("rst_daddr", 32'(drp_daddr), 32'd0);
    check("rst_di", 32'(drp_di), 32'd0);
    aresetn = 1'b1;

    // Single-entry RMW: 0xFFFF & 0xF000 | 0x0145 & 0x0FFF = 0xF145
    set_entry(0, DRP_CLKOUT0_REG1, 16'hF000, 16'h0145);
    d0 = den_cnt; w0 = wr_cnt; n0 = den_norst; o0 = den_ovl; k0 = done_cnt;
    pulse_start(1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rst_on", 32'(pll_rst), 32'd1);
    wait_end("t1", 2000, cyc);
    check("t1_done", {error, done}, 32'b01);
    check("t1_den_n", 32'(den_cnt - d0), 32'(TXN_PER_ENTRY));
    check("t1_wr_n", 32'(wr_cnt - w0), 32'd1);
    check("t1_di", 32'(last_di), 32'h0000F145);
    check("t1_waddr", 32'(last_wa), 32'h08);
    check("t1_rst_at_den", 32'(den_norst - n0), 32'd0);
    check("t1_den_overlap", 32'(den_ovl - o0), 32'd0);
    check("t1_mem", 32'(mem[8]), 32'h0000F145);
    @(negedge aclk);
    check("t1_done_1cyc", 32'(done_cnt - k0), 32'd1);
    check("t1_idle", {busy, done, pll_rst}, 32'd0);

    // num=0: reset held for RST_ASSERT + 16 hold cycles, no DRP traffic
    d0 = den_cnt; r0 = rst_cnt;
    pulse_start(0);
    wait_end("t2", 2000, cyc);
    check("t2_done", {error, done}, 32'b01);
    check("t2_den_n", 32'(den_cnt - d0), 32'd0);
    check("t2_rst_cycles", 32'(rst_cnt - r0), 32'd17);
    check("t2_rst_off", 32'(pll_rst), 32'd0);

    // No DRDY: error code 1 roughly 64 cycles after the read DEN
    m_rdy_en = 1'b0;
    pulse_start(1);
    cyc = 0;
    while (!drp_den && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    check("t3_den_seen", 32'(drp_den), 32'd1);
    wait_end("t3", 200, cyc);
    check("t3_latency_64", 32'(cyc >= 64 && cyc <= 66), 32'd1);
    check("t3_err", {error, err_code}, 32'b101);
    check("t3_rst_busy", {pll_rst, busy}, 32'd0);
    m_rdy_en = 1'b1;
    repeat (5) @(negedge aclk);

    // LOCKED never rises: error code 2, then a new start clears it
    lock_en = 1'b0;
    pulse_start(0);
    wait_end("t4", 70000, cyc);
    check("t4_err", {error, err_code}, 32'b110);
    check("t4_rst_off", 32'(pll_rst), 32'd0);
    check("t4_wait_len", 32'(cyc >= 65536 + 16), 32'd1);
    lock_en = 1'b1;
    pulse_start(0);
    check("t4_err_clear", {error, err_code}, 32'd0);
    wait_end("t4b", 2000, cyc);
    check("t4_done", {error, done}, 32'b01);

    // Start while busy is dropped
    set_entry(1, DRP_CLKOUT0_REG2, 16'h00FF, 16'h1200);
    d0 = den_cnt;
    pulse_start(1);
    repeat (3) @(negedge aclk);
    pulse_start(2);
    wait_end("t5", 2000, cyc);
    check("t5_done", {error, done}, 32'b01);
    check("t5_den_n", 32'(den_cnt - d0), 32'(TXN_PER_ENTRY));

    // Reset in the middle of a DRP write aborts everything
    pulse_start(2);
    cyc = 0;
    while (!(drp_den && drp_dwe) && cyc < 100) begin
      @(negedge aclk);
      cyc++;
    end
    check("t6_write_seen", 32'(drp_den && drp_dwe), 32'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("t6_abort_ctrl", {busy, done, error, err_code, drp_den, drp_dwe, pll_rst}, 32'd0);
    check("t6_abort_bus", {drp_daddr, drp_di}, 32'd0);
    aresetn = 1'b1;
    d0 = den_cnt;
    repeat (10) @(negedge aclk);
    check("t6_stays_idle", {32'(den_cnt - d0), busy, pll_rst}, 32'd0);

    // Corrupted readback bit
    refill();
    m_corrupt = 1'b1;
    pulse_start(1);
    wait_end("t7", 2000, cyc);
`ifdef PLL_DRP_READBACK_EN
    check("t7_verify_err", {error, err_code, done}, 32'b1110);
`else
    check("t7_no_verify", {error, done}, 32'b01);
`endif
    m_corrupt = 1'b0;

    // num=15 clamps to ENTRIES
    for (int i = 0; i < int'(ENTRIES); i++)
      set_entry(i, 7'(32'h20 + i), 16'h0000, 16'(32'h1000 + i));
    refill();
    w0 = wr_cnt;
    pulse_start(15);
    wait_end("t8", 5000, cyc);
    check("t8_done", {error, done}, 32'b01);
    check("t8_wr_n", 32'(wr_cnt - w0), 32'd8);
    check("t8_mem_first", 32'(mem[7'h20]), 32'h1000);
    check("t8_mem_last", 32'(mem[7'h27]), 32'h1007);
    check("t8_mem_beyond", 32'(mem[7'h28]), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
